// File: rtl/sound_pkg.sv
// Shared types for the note sequencer: FSM state encoding, note entry layout
// and the default tone-generator widths.
package sound_pkg;

  localparam int FREQ_W_DEF = 8;
  localparam int DUR_W_DEF  = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    GAP  = 2'd2
  } seq_state_t;

  typedef struct packed {
    logic [FREQ_W_DEF-1:0] freq;
    logic [DUR_W_DEF-1:0]  dur;
  } note_t;

endpackage

// File: rtl/note_sequencer_if.sv
// Host-side bus of the note sequencer: table write port, playback control and
// the status/tone outputs. Define NOTE_SEQ_LOOP_EN to add the loop control.
interface note_sequencer_if #(
  parameter int DEPTH  = 16,
  parameter int FREQ_W = 8,
  parameter int DUR_W  = 8
);
  localparam int ADDR_W = $clog2(DEPTH);

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [FREQ_W-1:0] wr_freq;
  logic [DUR_W-1:0]  wr_dur;
  logic [ADDR_W:0]   seq_len;
  logic              start;
  logic              stop;
`ifdef NOTE_SEQ_LOOP_EN
  logic              loop;
`endif
  logic [FREQ_W-1:0] frequency_control;
  logic              busy;
  logic [ADDR_W-1:0] note_idx;
  logic              done;

  modport master (
    output wr_en, wr_addr, wr_freq, wr_dur, seq_len, start, stop,
`ifdef NOTE_SEQ_LOOP_EN
    output loop,
`endif
    input  frequency_control, busy, note_idx, done
  );

  modport slave (
    input  wr_en, wr_addr, wr_freq, wr_dur, seq_len, start, stop,
`ifdef NOTE_SEQ_LOOP_EN
    input  loop,
`endif
    output frequency_control, busy, note_idx, done
  );
endinterface

// File: rtl/note_sequencer_prescaler.sv
// Tempo prescaler: one-cycle tick every TICK_DIV clocks, restartable via clear.
module tick_prescaler #(
  parameter int TICK_DIV = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tick
);
  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + ONE;
    if (clear || tick) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
endmodule

// File: rtl/note_sequencer.sv
// Melody sequencer: steps a note table through the tone generator's
// frequency_control. Define NOTE_SEQ_LOOP_EN to add looping playback.
module note_sequencer
  import sound_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int FREQ_W    = FREQ_W_DEF,
  parameter int DUR_W     = DUR_W_DEF,
  parameter int TICK_DIV  = 1000,
  parameter int GAP_TICKS = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  note_sequencer_if.slave  bus
);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int GAP_W  = $clog2(GAP_TICKS + 2);
  localparam logic [ADDR_W:0]   LEN_MAX  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   LEN_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] IDX_ONE  = ADDR_W'(1);
  localparam logic [DUR_W-1:0]  DUR_ONE  = DUR_W'(1);
  localparam logic [GAP_W-1:0]  GAP_ONE  = GAP_W'(1);
  localparam logic [GAP_W-1:0]  GAP_INIT = GAP_W'(GAP_TICKS);

  logic [DEPTH-1:0][FREQ_W-1:0] tbl_freq_q, tbl_freq_d;
  logic [DEPTH-1:0][DUR_W-1:0]  tbl_dur_q,  tbl_dur_d;

  seq_state_t        state_q, state_d;
  logic [FREQ_W-1:0] freq_q, freq_d;
  logic [ADDR_W-1:0] idx_q, idx_d, nxt_idx;
  logic [DUR_W-1:0]  dur_q, dur_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic              done_q, done_d;
  logic              tick, last, len_ok;

  // Idle holds the prescaler at zero so note 0 gets a full first tick.
  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_presc (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (state_q == IDLE),
    .tick  (tick)
  );

  function automatic logic [DUR_W-1:0] fix_dur(input logic [DUR_W-1:0] d);
    return (d == '0) ? DUR_ONE : d;
  endfunction

  always_comb begin
    tbl_freq_d = tbl_freq_q;
    tbl_dur_d  = tbl_dur_q;
    if (bus.wr_en) begin
      tbl_freq_d[bus.wr_addr] = bus.wr_freq;
      tbl_dur_d[bus.wr_addr]  = bus.wr_dur;
    end
  end

  assign len_ok  = (bus.seq_len != '0) && (bus.seq_len <= LEN_MAX);
  assign last    = ({1'b0, idx_q} == (len_q - LEN_ONE));
  assign nxt_idx = last ? '0 : idx_q + IDX_ONE;

  always_comb begin
    state_d = state_q;
    freq_d  = freq_q;
    idx_d   = idx_q;
    dur_d   = dur_q;
    gap_d   = gap_q;
    len_d   = len_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        freq_d = '0;
        idx_d  = '0;
        if (bus.start && len_ok) begin
          freq_d  = tbl_freq_q[0];
          dur_d   = fix_dur(tbl_dur_q[0]);
          len_d   = bus.seq_len;
          state_d = PLAY;
        end
      end
      PLAY: begin
        if (tick) begin
          if (dur_q == DUR_ONE) begin
`ifdef NOTE_SEQ_LOOP_EN
            done_d = last;
            if (!last || bus.loop) begin
`else
            if (!last) begin
`endif
              if (GAP_TICKS > 0) begin
                state_d = GAP;
                freq_d  = '0;
                gap_d   = GAP_INIT;
              end else begin
                idx_d  = nxt_idx;
                freq_d = tbl_freq_q[nxt_idx];
                dur_d  = fix_dur(tbl_dur_q[nxt_idx]);
              end
            end else begin
              state_d = IDLE;
              freq_d  = '0;
              idx_d   = '0;
              done_d  = 1'b1;
            end
          end else begin
            dur_d = dur_q - DUR_ONE;
          end
        end
      end
      GAP: begin
        freq_d = '0;
        if (tick) begin
          if (gap_q == GAP_ONE) begin
            state_d = PLAY;
            idx_d   = nxt_idx;
            freq_d  = tbl_freq_q[nxt_idx];
            dur_d   = fix_dur(tbl_dur_q[nxt_idx]);
          end else begin
            gap_d = gap_q - GAP_ONE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (bus.stop) begin
      state_d = IDLE;
      freq_d  = '0;
      idx_d   = '0;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tbl_freq_q <= '0;
      tbl_dur_q  <= '0;
      state_q    <= IDLE;
      freq_q     <= '0;
      idx_q      <= '0;
      dur_q      <= '0;
      gap_q      <= '0;
      len_q      <= '0;
      done_q     <= 1'b0;
    end else begin
      tbl_freq_q <= tbl_freq_d;
      tbl_dur_q  <= tbl_dur_d;
      state_q    <= state_d;
      freq_q     <= freq_d;
      idx_q      <= idx_d;
      dur_q      <= dur_d;
      gap_q      <= gap_d;
      len_q      <= len_d;
      done_q     <= done_d;
    end
  end

  assign bus.frequency_control = freq_q;
  assign bus.busy              = (state_q != IDLE);
  assign bus.note_idx          = idx_q;
  assign bus.done              = done_q;
endmodule

// File: tb/tb_note_sequencer.sv
// Directed bench for note_sequencer with TICK_DIV=4, GAP_TICKS=1.
module tb_note_sequencer;
  import sound_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  note_sequencer_if #(.DEPTH(16), .FREQ_W(8), .DUR_W(8)) bus ();

  note_sequencer #(
    .DEPTH(16), .FREQ_W(8), .DUR_W(8), .TICK_DIV(4), .GAP_TICKS(1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  task automatic chk(input string name, input int c, input int got, input int exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s cycle=%0d got=%0d exp=%0d", name, c, got, exp);
    end
  endtask

  task automatic write_entry(input int a, input note_t n);
    @(negedge clk);
    bus.wr_en = 1'b1; bus.wr_addr = 4'(a);
    bus.wr_freq = n.freq; bus.wr_dur = n.dur;
    @(negedge clk);
    bus.wr_en = 1'b0;
  endtask

  // Start is sampled at the next posedge; returns at the negedge after it (cycle 0).
  task automatic do_start(input int len);
    bus.seq_len = 5'(len); bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    if ({bus.frequency_control, bus.busy, bus.note_idx, bus.done} !== 14'd0) begin
      tests_failed++;
      $display("FAIL reset_outputs got=%0h exp=0",
               {bus.frequency_control, bus.busy, bus.note_idx, bus.done});
    end
    tests_run++;
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_melody();
    int ef, ei;
    write_entry(0, '{freq: 8'd20, dur: 8'd2});
    write_entry(1, '{freq: 8'd5,  dur: 8'd1});
    write_entry(2, '{freq: 8'd0,  dur: 8'd1});
    @(negedge clk);
    do_start(3);
    for (int c = 0; c < 25; c++) begin
      if (c < 8)       begin ef = 20; ei = 0; end
      else if (c < 12) begin ef = 0;  ei = 0; end
      else if (c < 16) begin ef = 5;  ei = 1; end
      else if (c < 20) begin ef = 0;  ei = 1; end
      else if (c < 24) begin ef = 0;  ei = 2; end
      else             begin ef = 0;  ei = 0; end
      chk("melody_freq", c, bus.frequency_control, ef);
      chk("melody_idx",  c, bus.note_idx, ei);
      chk("melody_busy", c, bus.busy, (c < 24) ? 1 : 0);
      chk("melody_done", c, bus.done, (c == 24) ? 1 : 0);
      @(negedge clk);
    end
    chk("melody_done_once", 25, bus.done, 0);
  endtask

  task automatic test_stop();
    do_start(3);
    chk("stop_pre_freq", 0, bus.frequency_control, 20);
    @(negedge clk); @(negedge clk);
    bus.stop = 1'b1;
    @(negedge clk);
    bus.stop = 1'b0;
    chk("stop_freq", 3, bus.frequency_control, 0);
    chk("stop_busy", 3, bus.busy, 0);
    chk("stop_done", 3, bus.done, 0);
    @(negedge clk);
    chk("stop_no_done", 4, bus.done, 0);
  endtask

  task automatic test_ignored_start();
    do_start(0);
    chk("len0_busy", 0, bus.busy, 0);
    do_start(17);
    chk("len17_busy", 0, bus.busy, 0);
    bus.stop = 1'b1;
    do_start(3);
    bus.stop = 1'b0;
    chk("start_stop_busy", 0, bus.busy, 0);
    chk("start_stop_freq", 0, bus.frequency_control, 0);
  endtask

  task automatic test_rewrite();
    int ef;
    @(negedge clk);
    do_start(2);
    for (int c = 0; c < 17; c++) begin
      if (c < 8)       ef = 20;
      else if (c < 12) ef = 0;
      else if (c < 16) ef = 7;
      else             ef = 0;
      chk("rewrite_freq", c, bus.frequency_control, ef);
      if (c == 16) chk("rewrite_done", c, bus.done, 1);
      bus.wr_en = (c == 2) || (c == 3);
      bus.wr_addr = (c == 2) ? 4'd1 : 4'd0;
      bus.wr_freq = (c == 2) ? 8'd7 : 8'd99;
      bus.wr_dur  = (c == 2) ? 8'd1 : 8'd3;
      @(negedge clk);
    end
    bus.wr_en = 1'b0;
  endtask

  task automatic test_zero_dur();
    write_entry(0, '{freq: 8'd30, dur: 8'd0});
    @(negedge clk);
    do_start(1);
    for (int c = 0; c < 5; c++) begin
      chk("dur0_freq", c, bus.frequency_control, (c < 4) ? 30 : 0);
      chk("dur0_done", c, bus.done, (c == 4) ? 1 : 0);
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid_play();
    write_entry(0, '{freq: 8'd40, dur: 8'd5});
    @(negedge clk);
    do_start(1);
    chk("rst_pre_freq", 0, bus.frequency_control, 40);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_freq", 2, bus.frequency_control, 0);
    chk("rst_busy", 2, bus.busy, 0);
    chk("rst_idx", 2, bus.note_idx, 0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    // Cleared entry 0 is a rest with duration 0 -> exactly one tick.
    do_start(1);
    for (int c = 0; c < 5; c++) begin
      chk("rst_tbl_freq", c, bus.frequency_control, 0);
      chk("rst_tbl_busy", c, bus.busy, (c < 4) ? 1 : 0);
      chk("rst_tbl_done", c, bus.done, (c == 4) ? 1 : 0);
      @(negedge clk);
    end
  endtask

`ifdef NOTE_SEQ_LOOP_EN
  task automatic test_loop();
    int ef;
    write_entry(0, '{freq: 8'd11, dur: 8'd1});
    write_entry(1, '{freq: 8'd22, dur: 8'd1});
    @(negedge clk);
    bus.loop = 1'b1;
    do_start(2);
    for (int c = 0; c < 29; c++) begin
      case ((c % 16) / 4)
        0: ef = 11;
        2: ef = 22;
        default: ef = 0;
      endcase
      if (c == 28) ef = 0;
      chk("loop_freq", c, bus.frequency_control, ef);
      chk("loop_done", c, bus.done, (c == 12 || c == 28) ? 1 : 0);
      chk("loop_busy", c, bus.busy, (c < 28) ? 1 : 0);
      if (c == 14) bus.loop = 1'b0;
      @(negedge clk);
    end
  endtask
`endif

  initial begin
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_freq = '0; bus.wr_dur = '0;
    bus.seq_len = '0; bus.start = 1'b0; bus.stop = 1'b0;
`ifdef NOTE_SEQ_LOOP_EN
    bus.loop = 1'b0;
`endif
    test_reset();
    test_melody();
    test_stop();
    test_ignored_start();
    test_rewrite();
    test_zero_dur();
    test_reset_mid_play();
`ifdef NOTE_SEQ_LOOP_EN
    test_loop();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
